// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// sprite-unit wait with timeout, sticky halt and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned SPRITE_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_s_reg,
  input  logic [4:0]       ID_t_reg,
  input  logic             ID_uses_s,
  input  logic             ID_uses_t,
  input  logic [4:0]       EX_dst_reg,
  input  logic             EX_use_dst_reg,
  input  logic             EX_mem_re,
  input  logic             EX_branch_taken,
  input  logic             EX_sprite_req,
  input  logic             sprite_done,
  input  logic             WB_hlt_instr,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             hlt,
  output logic             sprite_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_SPRITE_WAIT = 2'd1;
  localparam logic [1:0] ST_HALTED      = 2'd2;

  localparam logic [11:0] TIMEOUT_LIM = SPRITE_TIMEOUT[11:0];

  logic [1:0]  state, state_nxt;
  logic [11:0] wait_cnt, wait_cnt_nxt;
  logic        load_use;
  logic        run_rules;
  logic        timeout_hit;

  assign load_use = EX_mem_re && EX_use_dst_reg && (EX_dst_reg != 5'd0) &&
                    ((ID_uses_s && (ID_s_reg == EX_dst_reg)) ||
                     (ID_uses_t && (ID_t_reg == EX_dst_reg)));

  always_comb begin
    stall_PC     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    run_rules    = 1'b0;
    timeout_hit  = 1'b0;

    case (state)
      ST_RUN: begin
        if (WB_hlt_instr) begin
          state_nxt = ST_HALTED;
        end else if (EX_sprite_req && !sprite_done) begin
          stall_PC     = 1'b1;
          stall_IF_ID  = 1'b1;
          stall_ID_EX  = 1'b1;
          stall_EX_MEM = 1'b1;
          state_nxt    = ST_SPRITE_WAIT;
          wait_cnt_nxt = 12'd1;
        end else begin
          run_rules = 1'b1;
        end
      end
      ST_SPRITE_WAIT: begin
        if (!sprite_done && (wait_cnt < TIMEOUT_LIM)) begin
          stall_PC     = 1'b1;
          stall_IF_ID  = 1'b1;
          stall_ID_EX  = 1'b1;
          stall_EX_MEM = 1'b1;
          wait_cnt_nxt = wait_cnt + 12'd1;
        end else begin
          // Release (done or timed out) behaves like RUN with the sprite request masked.
          timeout_hit = !sprite_done;
          if (WB_hlt_instr) begin
            state_nxt = ST_HALTED;
          end else begin
            state_nxt = ST_RUN;
            run_rules = 1'b1;
          end
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase

    if (run_rules) begin
      if (EX_branch_taken) begin
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (load_use) begin
        stall_PC    = 1'b1;
        stall_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      wait_cnt       <= '0;
      hlt            <= 1'b0;
      sprite_timeout <= 1'b0;
      stall_count    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ST_HALTED) hlt <= 1'b1;
      if (timeout_hit) sprite_timeout <= 1'b1;
      if (stall_PC && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (CNT_W=4 to reach saturation, timeout 8).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_s_reg, ID_t_reg, EX_dst_reg;
  logic       ID_uses_s, ID_uses_t, EX_use_dst_reg, EX_mem_re;
  logic       EX_branch_taken, EX_sprite_req, sprite_done, WB_hlt_instr;
  logic       stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
  logic       flush_IF_ID, flush_ID_EX, hlt, sprite_timeout;
  logic [3:0] stall_count;
  logic [5:0] ctl;

  int tests  = 0;
  int failed = 0;

  // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID, flush_ID_EX}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110001;
  localparam logic [5:0] C_SPR  = 6'b111100;
  localparam logic [5:0] C_BR   = 6'b000011;

  always #5 clk = ~clk;

  assign ctl = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, flush_IF_ID, flush_ID_EX};

  pipeline_hazard_ctrl #(.CNT_W(4), .SPRITE_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_s_reg(ID_s_reg), .ID_t_reg(ID_t_reg), .ID_uses_s(ID_uses_s), .ID_uses_t(ID_uses_t),
    .EX_dst_reg(EX_dst_reg), .EX_use_dst_reg(EX_use_dst_reg), .EX_mem_re(EX_mem_re),
    .EX_branch_taken(EX_branch_taken), .EX_sprite_req(EX_sprite_req), .sprite_done(sprite_done),
    .WB_hlt_instr(WB_hlt_instr),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .hlt(hlt), .sprite_timeout(sprite_timeout), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ID_s_reg = '0; ID_t_reg = '0; EX_dst_reg = '0;
    ID_uses_s = 1'b0; ID_uses_t = 1'b0; EX_use_dst_reg = 1'b0; EX_mem_re = 1'b0;
    EX_branch_taken = 1'b0; EX_sprite_req = 1'b0; sprite_done = 1'b0; WB_hlt_instr = 1'b0;
  endtask

  task automatic load_r3(input logic [4:0] s, input logic [4:0] t,
                         input logic us, input logic ut, input logic [4:0] dst);
    EX_mem_re = 1'b1; EX_use_dst_reg = 1'b1; EX_dst_reg = dst;
    ID_s_reg = s; ID_t_reg = t; ID_uses_s = us; ID_uses_t = ut;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("reset_ctl", ctl, C_NONE);
    chk("reset_cnt", stall_count, 4'd0);
    chk("reset_hlt", hlt, 1'b0);
    chk("reset_to", sprite_timeout, 1'b0);

    // load-use on s
    load_r3(5'd3, 5'd0, 1'b1, 1'b0, 5'd3);
    settle();
    chk("lu_s_ctl", ctl, C_LU);
    tick();
    idle();
    settle();
    chk("lu_s_after", ctl, C_NONE);
    chk("lu_s_cnt", stall_count, 4'd1);

    // r0 never hazards; unread t never hazards; read t hazards
    load_r3(5'd0, 5'd0, 1'b1, 1'b0, 5'd0);
    settle();
    chk("lu_r0", ctl, C_NONE);
    load_r3(5'd0, 5'd3, 1'b0, 1'b0, 5'd3);
    settle();
    chk("lu_t_unused", ctl, C_NONE);
    load_r3(5'd0, 5'd3, 1'b0, 1'b1, 5'd3);
    settle();
    chk("lu_t_ctl", ctl, C_LU);
    tick();
    idle();
    settle();
    chk("lu_t_cnt", stall_count, 4'd2);

    // sprite op, done on 5th cycle
    EX_sprite_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk($sformatf("spr_stall%0d", i), ctl, C_SPR);
      tick();
    end
    sprite_done = 1'b1;
    settle();
    chk("spr_release", ctl, C_NONE);
    tick();
    idle();
    settle();
    chk("spr_after", ctl, C_NONE);
    chk("spr_cnt", stall_count, 4'd6);

    // sprite op with held branch; load-use also present on release
    EX_sprite_req = 1'b1; EX_branch_taken = 1'b1;
    settle();
    chk("sbr_c1", ctl, C_SPR);
    tick();
    settle();
    chk("sbr_c2", ctl, C_SPR);
    tick();
    sprite_done = 1'b1;
    load_r3(5'd4, 5'd0, 1'b1, 1'b0, 5'd4);
    settle();
    chk("sbr_c3", ctl, C_BR);
    tick();
    idle();
    settle();
    chk("sbr_after", ctl, C_NONE);
    chk("sbr_cnt", stall_count, 4'd8);

    // timeout: 8 stall cycles then forced release, counter saturates at 15
    EX_sprite_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      settle();
      chk($sformatf("to_stall%0d", i), ctl, C_SPR);
      chk($sformatf("to_flag%0d", i), sprite_timeout, 1'b0);
      tick();
    end
    settle();
    chk("to_release", ctl, C_NONE);
    tick();
    EX_sprite_req = 1'b0;
    settle();
    chk("to_sticky", sprite_timeout, 1'b1);
    chk("to_cnt_sat", stall_count, 4'd15);
    chk("to_run", ctl, C_NONE);

    load_r3(5'd7, 5'd0, 1'b1, 1'b0, 5'd7);
    settle();
    chk("sat_lu_ctl", ctl, C_LU);
    tick();
    idle();
    settle();
    chk("sat_hold", stall_count, 4'd15);
    chk("to_sticky2", sprite_timeout, 1'b1);

    // halt beats a simultaneous load-use
    WB_hlt_instr = 1'b1;
    load_r3(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
    settle();
    chk("hlt_ctl", ctl, C_NONE);
    chk("hlt_not_yet", hlt, 1'b0);
    tick();
    WB_hlt_instr = 1'b0;
    EX_sprite_req = 1'b1;
    settle();
    chk("hlt_set", hlt, 1'b1);
    chk("hlt_no_stall", ctl, C_NONE);
    tick();
    tick();
    settle();
    chk("hlt_sticky", hlt, 1'b1);
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("rst_hlt", hlt, 1'b0);
    chk("rst_cnt", stall_count, 4'd0);
    chk("rst_to", sprite_timeout, 1'b0);

    // reset while waiting on the sprite unit
    EX_sprite_req = 1'b1;
    settle();
    chk("sw_enter", ctl, C_SPR);
    tick();
    EX_sprite_req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("sw_rst_ctl", ctl, C_NONE);
    chk("sw_rst_cnt", stall_count, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
